// File: rtl/isqrt_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency, in-order isqrt pipeline among NREQ requesters.
// A tag FIFO records the owner of each in-flight operation. Optional checker: ISQRT_PIPE_ARBITER_CHECK_EN.
module isqrt_pipe_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned TAG_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*32-1:0]   req_x,
    output logic [NREQ-1:0]      req_rdy,
    output logic [NREQ-1:0]      rsp_vld,
    output logic [15:0]          rsp_y,
    output logic                 isqrt_x_vld,
    output logic [31:0]          isqrt_x,
    input  logic                 isqrt_y_vld,
    input  logic [15:0]          isqrt_y
`ifdef ISQRT_PIPE_ARBITER_CHECK_EN
    ,
    output logic                 err
`endif
);

    localparam int unsigned TW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned AW = $clog2(TAG_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [TW-1:0]   rr_q;
    logic [TW-1:0]   tag_mem [TAG_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] rsp_vld_q;
    logic [15:0]     rsp_y_q;

    logic            pop, full, issue, gnt_found;
    logic [TW-1:0]   gnt_idx, cand;

    function automatic logic [TW-1:0] rr_idx(input logic [TW-1:0] base, input int unsigned k);
        int unsigned s;
        s = (32'(base) + k) % NREQ;
        return TW'(s);
    endfunction

    // A result returning into an empty FIFO belongs to no one (e.g. issued before reset).
    assign pop  = isqrt_y_vld && (cnt_q != '0);
    assign full = (cnt_q == CW'(TAG_DEPTH)) && !pop;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = rr_idx(rr_q, k);
            if (!gnt_found && req_vld[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign issue       = gnt_found && !full;
    assign req_rdy     = issue ? (NREQ'(1) << gnt_idx) : '0;
    assign isqrt_x_vld = issue;
    assign isqrt_x     = issue ? req_x[{gnt_idx, 5'b0} +: 32] : '0;

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_q] <= gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            rr_q      <= TW'(NREQ - 1);
            rsp_vld_q <= '0;
            rsp_y_q   <= '0;
        end else begin
            if (issue) begin
                wr_q <= wr_q + AW'(1);
                rr_q <= gnt_idx;
            end
            if (pop) begin
                rd_q    <= rd_q + AW'(1);
                rsp_y_q <= isqrt_y;
            end
            case ({issue, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            rsp_vld_q <= pop ? (NREQ'(1) << tag_mem[rd_q]) : '0;
        end
    end

    assign rsp_vld = rsp_vld_q;
    assign rsp_y   = rsp_y_q;

`ifdef ISQRT_PIPE_ARBITER_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((isqrt_y_vld && (cnt_q == '0) && !issue) ||
                     (issue && (cnt_q == CW'(TAG_DEPTH)) && !pop)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_isqrt_pipe_arbiter.sv
// Bench for isqrt_pipe_arbiter: two instances (deep and 2-entry tag FIFO) on latency-4 isqrt models,
// scoreboarded against a per-requester expected-result queue and a round-robin grant model.
module tb_isqrt_pipe_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_vld;
    logic [NREQ*32-1:0]   req_x;

    logic [NREQ-1:0] rdy [2];
    logic [NREQ-1:0] rsp [2];
    logic [15:0]     rspy [2];
    logic            xv [2];
    logic [31:0]     xx [2];
    logic            yv [2];
    logic [15:0]     yy [2];
`ifdef ISQRT_PIPE_ARBITER_CHECK_EN
    logic            err [2];
`endif

    logic        pv [2][LAT] = '{default: 1'b0};
    logic [15:0] py [2][LAT] = '{default: 16'd0};

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    isqrt_pipe_arbiter #(.NREQ(NREQ), .TAG_DEPTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_x(req_x), .req_rdy(rdy[0]),
        .rsp_vld(rsp[0]), .rsp_y(rspy[0]), .isqrt_x_vld(xv[0]), .isqrt_x(xx[0]),
        .isqrt_y_vld(yv[0]), .isqrt_y(yy[0])
`ifdef ISQRT_PIPE_ARBITER_CHECK_EN
        , .err(err[0])
`endif
    );

    isqrt_pipe_arbiter #(.NREQ(NREQ), .TAG_DEPTH(2)) u_small (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_x(req_x), .req_rdy(rdy[1]),
        .rsp_vld(rsp[1]), .rsp_y(rspy[1]), .isqrt_x_vld(xv[1]), .isqrt_x(xx[1]),
        .isqrt_y_vld(yv[1]), .isqrt_y(yy[1])
`ifdef ISQRT_PIPE_ARBITER_CHECK_EN
        , .err(err[1])
`endif
    );

    function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
        longint unsigned r, t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return 16'(r);
    endfunction

    // Latency-4 isqrt models; deliberately not reset so stale results still come back.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pv[d][0] <= xv[d];
            py[d][0] <= ref_sqrt(xx[d]);
            for (int s = 1; s < LAT; s++) begin
                pv[d][s] <= pv[d][s-1];
                py[d][s] <= py[d][s-1];
            end
        end
    end
    assign yv[0] = pv[0][LAT-1];
    assign yy[0] = py[0][LAT-1];
    assign yv[1] = pv[1][LAT-1];
    assign yy[1] = py[1][LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [15:0] expq [2*NREQ][$];
    int          inflight [2];
    int          last [2];
    int          depth [2] = '{16, 2};

    initial begin
        int idx;
        logic [NREQ-1:0] eg;
        logic [31:0] ex;
        logic m_pop, m_full;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    for (int i = 0; i < NREQ; i++) expq[d*NREQ+i].delete();
                    inflight[d] = 0;
                    last[d]     = NREQ - 1;
                end else begin
                    if (rsp[d] != '0) begin
                        check($sformatf("d%0d rsp_vld one-hot", d), 64'($onehot(rsp[d])), 64'd1);
                        if ($onehot(rsp[d])) begin
                            idx = $clog2(rsp[d]);
                            if (expq[d*NREQ+idx].size() == 0)
                                check($sformatf("d%0d unexpected rsp", d), 64'(rsp[d]), 64'd0);
                            else
                                check($sformatf("d%0d rsp_y req%0d", d, idx), 64'(rspy[d]),
                                      64'(expq[d*NREQ+idx].pop_front()));
                        end
                    end
                    m_pop  = yv[d] && (inflight[d] > 0);
                    m_full = (inflight[d] == depth[d]) && !m_pop;
                    eg = '0;
                    ex = '0;
                    if (!m_full) begin
                        for (int k = 1; k <= NREQ; k++) begin
                            idx = (last[d] + k) % NREQ;
                            if (eg == '0 && req_vld[idx]) begin
                                eg = NREQ'(1) << idx;
                                ex = req_x[32*idx +: 32];
                            end
                        end
                    end
                    check($sformatf("d%0d req_rdy", d), 64'(rdy[d]), 64'(eg));
                    check($sformatf("d%0d isqrt_x_vld", d), 64'(xv[d]), 64'(eg != '0));
                    check($sformatf("d%0d isqrt_x", d), 64'(xx[d]), 64'(ex));
                    if ((rdy[d] & req_vld) != '0) begin
                        idx = $clog2(rdy[d] & req_vld);
                        expq[d*NREQ+idx].push_back(ref_sqrt(req_x[32*idx +: 32]));
                        inflight[d]++;
                        last[d] = idx;
                    end
                    if (m_pop) inflight[d]--;
                end
            end
        end
    end

    typedef struct {
        int          r;
        logic [31:0] x;
        logic [15:0] y;
    } vec_t;

    initial begin
        vec_t tbl [8];
        tbl[0] = '{1, 32'd144, 16'd12};
        tbl[1] = '{0, 32'd0, 16'd0};
        tbl[2] = '{2, 32'd1, 16'd1};
        tbl[3] = '{3, 32'd15, 16'd3};
        tbl[4] = '{2, 32'd16, 16'd4};
        tbl[5] = '{1, 32'd65535, 16'd255};
        tbl[6] = '{0, 32'd65536, 16'd256};
        tbl[7] = '{3, 32'hFFFF_FFFF, 16'hFFFF};

        rst_n   = 1'b0;
        req_vld = '0;
        req_x   = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset rsp_vld", d), 64'(rsp[d]), 64'd0);
            check($sformatf("d%0d reset rsp_y", d), 64'(rspy[d]), 64'd0);
            check($sformatf("d%0d idle rdy", d), 64'(rdy[d]), 64'd0);
        end

        // Priority rotation: req 0 first, then 3 beats 0
        req_vld = 4'b0001;
        req_x[0 +: 32] = 32'd16;
        #1 for (int d = 0; d < 2; d++) check($sformatf("d%0d rot grant0", d), 64'(rdy[d]), 64'd1);
        tick();
        req_vld = 4'b1001;
        req_x[96 +: 32] = 32'd25;
        #1 for (int d = 0; d < 2; d++) check($sformatf("d%0d rot grant3", d), 64'(rdy[d]), 64'h8);
        tick();

        // All four valid: grants rotate 0,1,2,3,...
        for (int k = 0; k < 8; k++) begin
            req_vld = 4'b1111;
            for (int i = 0; i < NREQ; i++) req_x[32*i +: 32] = 32'(i * i + 100 * k);
            #1 check($sformatf("rr grant k=%0d", k), 64'(rdy[0]), 64'(1 << (k % 4)));
            tick();
        end
        req_vld = '0;
        repeat (12) tick();

        // Single-issue vectors with fixed expected results
        for (int e = 0; e < 8; e++) begin
            req_x[32*tbl[e].r +: 32] = tbl[e].x;
            req_vld = NREQ'(1) << tbl[e].r;
            #1 for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d vec%0d rdy", d, e), 64'(rdy[d]), 64'(1 << tbl[e].r));
                check($sformatf("d%0d vec%0d isqrt_x", d, e), 64'(xx[d]), 64'(tbl[e].x));
            end
            tick();
            req_vld = '0;
            repeat (LAT) tick();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d vec%0d rsp_vld", d, e), 64'(rsp[d]), 64'(1 << tbl[e].r));
                check($sformatf("d%0d vec%0d rsp_y", d, e), 64'(rspy[d]), 64'(tbl[e].y));
            end
            tick();
        end

        // x=0 from req 2 then all-ones from req 3 return in issue order
        req_vld = 4'b0100;
        req_x[64 +: 32] = 32'd0;
        tick();
        req_vld = 4'b1000;
        req_x[96 +: 32] = 32'hFFFF_FFFF;
        tick();
        req_vld = '0;
        repeat (LAT - 1) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d pair first vld", d), 64'(rsp[d]), 64'h4);
            check($sformatf("d%0d pair first y", d), 64'(rspy[d]), 64'h0);
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d pair second vld", d), 64'(rsp[d]), 64'h8);
            check($sformatf("d%0d pair second y", d), 64'(rspy[d]), 64'hFFFF);
        end
        tick();

        // Two requesters always valid: exercises the full 2-entry FIFO
        for (int c = 0; c < 30; c++) begin
            req_vld = 4'b0011;
            req_x[0 +: 32]  = $urandom;
            req_x[32 +: 32] = $urandom;
            tick();
        end

        for (int c = 0; c < 400; c++) begin
            req_vld = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) req_x[32*i +: 32] = $urandom;
            tick();
        end
        req_vld = '0;
        repeat (12) tick();

        // Reset with operations in flight; stale returns must be dropped
        for (int c = 0; c < 3; c++) begin
            req_vld = 4'b0111;
            for (int i = 0; i < NREQ; i++) req_x[32*i +: 32] = $urandom;
            tick();
        end
        req_vld = '0;
        rst_n   = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d post-reset rsp_vld", d), 64'(rsp[d]), 64'd0);
`ifdef ISQRT_PIPE_ARBITER_CHECK_EN
            check($sformatf("d%0d err after reset", d), 64'(err[d]), 64'd0);
`endif
        end
        tick();
`ifdef ISQRT_PIPE_ARBITER_CHECK_EN
        for (int d = 0; d < 2; d++) check($sformatf("d%0d err on stale", d), 64'(err[d]), 64'd1);
`endif
        repeat (4) tick();

        req_vld = 4'b0010;
        req_x[32 +: 32] = 32'd1000000;
        tick();
        req_vld = '0;
        repeat (LAT) tick();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d after-reset rsp_vld", d), 64'(rsp[d]), 64'h2);
            check($sformatf("d%0d after-reset rsp_y", d), 64'(rspy[d]), 64'd1000);
        end
        repeat (8) tick();

        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d inflight drained", d), 64'(inflight[d]), 64'd0);
            for (int i = 0; i < NREQ; i++)
                check($sformatf("d%0d req%0d responses lost", d, i),
                      64'(expq[d*NREQ+i].size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/isqrt_pipe_arbiter.md
Name: isqrt_pipe_arbiter

Overview:
- Shares one pipelined isqrt instance (32-bit in, 16-bit out, fixed latency, in-order, no stall) among NREQ independent requesters.
- Issues at most one argument per cycle, with round-robin priority.
- Tracks the owner of each in-flight operation in a tag FIFO and routes each result back to the requester that issued it.
- Sits between the formula FSMs and the single isqrt instance at the top level.

Parameters:
- NREQ, 4: number of requesters; legal range 2..8.
- TAG_DEPTH, 16: tag FIFO entries; sets the maximum number of in-flight operations. Must be at least the isqrt latency to sustain one issue per cycle. Power of 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- req_vld  in  NREQ  per-requester argument valid
- req_x  in  NREQ*32  per-requester argument; requester i uses bits [32*i+31:32*i]
- req_rdy  out  NREQ  one-hot grant; a transfer happens when req_vld[i] and req_rdy[i] are both high
- rsp_vld  out  NREQ  one-hot result valid, registered
- rsp_y  out  16  result data, shared by all requesters, qualified by rsp_vld
- isqrt_x_vld  out  1  to isqrt
- isqrt_x  out  32  to isqrt
- isqrt_y_vld  in  1  from isqrt
- isqrt_y  in  16  from isqrt

Behaviour:
- Reset (rst_n low at posedge clk):
  - tag FIFO emptied; count=0.
  - rr pointer = NREQ-1, so requester 0 has highest priority first.
  - rsp_vld=0, rsp_y=0.
  - req_rdy and isqrt_x_vld are combinational; they are 0 while the FIFO is full and when no request is pending.
- Issue enable: full = (count==TAG_DEPTH) and no pop this cycle. A same-cycle pop frees a slot, so a full FIFO with isqrt_y_vld still issues.
- Grant (combinational):
  - the first i with req_vld[i]=1, scanning from rr+1 upward modulo NREQ.
  - req_rdy[i]=1 only for that i, and only when issue is enabled.
  - req_rdy is 0 for requesters with req_vld low.
- Issue: isqrt_x_vld = any grant; isqrt_x = req_x of the granted requester, 0 when idle.
  - On issue: push granted index into the tag FIFO; rr <= granted index.
  - With no issue, rr holds.
- Return: on isqrt_y_vld, pop the FIFO head tag t.
  - Next cycle: rsp_vld = one-hot(t), rsp_y = isqrt_y.
  - Otherwise rsp_vld = 0 and rsp_y holds its last value.
- Latency: request handshake to rsp_vld = isqrt latency + 1 cycle.
- Throughput: one issue and one return per cycle when TAG_DEPTH is at least the isqrt latency.
- Simultaneous push and pop: count is unchanged; pointers advance independently and wrap modulo TAG_DEPTH.
- Ordering: results to a given requester return in its issue order; requesters have no back-pressure on responses.
- isqrt_y_vld with an empty FIFO (e.g. a result returning after mid-operation reset): result is dropped, no rsp_vld.
- Reset mid-operation: all in-flight tags are discarded. rsp_vld is 0 the cycle after reset.
- Fairness: a continuously requesting requester is granted within NREQ issue opportunities.

Optional Feature:
- Macro: ISQRT_PIPE_ARBITER_CHECK_EN.
- Defined: adds output err (1 bit), a sticky flag cleared only by reset.
  - err sets when isqrt_y_vld arrives with the FIFO empty and no push in that cycle.
  - err also sets when a push occurs while count==TAG_DEPTH and there is no pop; this indicates a design bug.
  - err becomes visible one cycle after the event.
- Not defined: no err port and no check logic; dropping on empty is unchanged.

Test Plan:
- Single requester: req 1 issues x=144 (latency-4 isqrt model) -> isqrt_x=144 at issue; rsp_vld=4'b0010 and rsp_y=12 five cycles later; no other rsp_vld.
- All four requesters valid for 8 cycles with x=i*i+100*k -> grants follow the order 0,1,2,3,0,1,2,3; each response matches isqrt of its own argument and goes to the correct owner.
- TAG_DEPTH=2 with a latency-4 model, two requesters always valid -> at most 2 operations in flight; req_rdy drops to 0 while full; issue resumes in the same cycle as isqrt_y_vld; no response is lost.
- x=0 and x=32'hFFFF_FFFF from requesters 2 and 3 -> rsp_y=0 to req 2, then rsp_y=16'hFFFF to req 3, in issue order.
- rst_n low for 1 cycle with 3 operations in flight -> rsp_vld stays 0 for the stale returns; a new request after reset gets a correct response.
  - With ISQRT_PIPE_ARBITER_CHECK_EN defined: err=1 one cycle after the first stale return.
- Priority rotation: req 0 granted, then req 0 and req 3 both valid -> req 3 granted before req 0.
